// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage definitions: state encoding, reset PC, halt opcode.
package fetch_pc_unit_pkg;

    localparam int          ADDR_W   = 16;
    localparam int          INST_W   = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [3:0]  HLT_OP   = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_HOLD,
        ST_HALTED
    } state_e;

    function automatic logic is_hlt(input logic [INST_W-1:0] inst);
        return inst[INST_W-1 -: 4] == HLT_OP;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_cla.sv
// 16-bit adder: ripple inside 4-bit groups, carry lookahead across groups.
module cla_16bit (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_cout,
    output logic        o_ovfl
);
    logic [15:0] w_g, w_p;
    logic [16:0] w_c;
    logic [3:0]  w_gg, w_gp;

    assign w_g    = i_a & i_b;
    assign w_p    = i_a ^ i_b;
    assign w_c[0] = i_cin;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        assign w_gp[k] = &w_p[4*k +: 4];
        assign w_gg[k] = w_g[4*k+3]
                       | (w_p[4*k+3] & w_g[4*k+2])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
        for (genvar j = 0; j < 3; j++) begin : g_bit
            assign w_c[4*k+j+1] = w_g[4*k+j] | (w_p[4*k+j] & w_c[4*k+j]);
        end
    end

    // Group carries resolved directly from the group generate/propagate terms
    assign w_c[4]  = w_gg[0] | (w_gp[0] & w_c[0]);
    assign w_c[8]  = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & w_c[0]);
    assign w_c[12] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & w_c[0]);
    assign w_c[16] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & w_c[0]);

    assign o_sum  = w_p ^ w_c[15:0];
    assign o_cout = w_c[16];
    assign o_ovfl = w_c[16] ^ w_c[15];
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC owner: issues I-mem requests, survives misses, hands instructions
// to IF/ID and applies taken-branch redirects with wrong-path squashing.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              imem_valid,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);
    state_e            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt, r_pend_pc, w_pend_nxt, r_bpc, w_bpc_nxt;
    logic [INST_W-1:0] r_buf, w_buf_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_cout, w_ovfl;

    cla_16bit u_pc_inc (
        .i_a    (r_pc),
        .i_b    (16'd2),
        .i_cin  (1'b0),
        .o_sum  (w_pc_inc),
        .o_cout (w_cout),
        .o_ovfl (w_ovfl)
    );

    assign imem_addr = r_pc;
    assign pc_out    = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= RESET_PC;
            r_pend_pc <= '0;
            r_buf     <= '0;
            r_bpc     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_pend_pc <= w_pend_nxt;
            r_buf     <= w_buf_nxt;
            r_bpc     <= w_bpc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend_pc;
        w_buf_nxt   = r_buf;
        w_bpc_nxt   = r_bpc;
        imem_req    = 1'b0;
        if_valid    = 1'b0;
        if_inst     = '0;
        if_pc       = '0;
        halted      = 1'b0;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_RUN;
            ST_RUN: begin
                imem_req = 1'b1;
                if_inst  = imem_data;
                if_pc    = r_pc;
                if (redirect_valid) begin
                    if (imem_valid) begin
                        w_pc_nxt = redirect_pc;
                    end else begin
                        w_pend_nxt  = redirect_pc;
                        w_state_nxt = ST_DRAIN;
                    end
                end else if (imem_valid) begin
                    if_valid = 1'b1;
                    w_pc_nxt = w_pc_inc;
                    if (stall) begin
                        w_buf_nxt   = imem_data;
                        w_bpc_nxt   = r_pc;
                        w_state_nxt = ST_HOLD;
                    end else if (is_hlt(imem_data)) begin
                        w_state_nxt = ST_HALTED;
                    end
                end
            end
            // Keep the old address up until the outstanding miss returns
            ST_DRAIN: begin
                imem_req = 1'b1;
                if (redirect_valid) w_pend_nxt = redirect_pc;
                if (imem_valid) begin
                    w_pc_nxt    = redirect_valid ? redirect_pc : r_pend_pc;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HOLD: begin
                if_valid = ~redirect_valid;
                if_inst  = r_buf;
                if_pc    = r_bpc;
                if (redirect_valid) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = ST_RUN;
                end else if (!stall) begin
                    w_state_nxt = is_hlt(r_buf) ? ST_HALTED : ST_RUN;
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
                if (redirect_valid) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with an I-mem model and delivery scoreboard.
module tb_fetch_pc_unit;
    logic        clk = 1'b0;
    logic        rst_n, redirect_valid, stall, hit;
    logic [15:0] redirect_pc, hlt_addr;
    logic        imem_req, imem_valid, if_valid, halted;
    logic [15:0] imem_addr, imem_data, if_inst, if_pc, pc_out;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] inst;
    } exp_t;

    exp_t sb[$];
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [15:0] a);
        logic [15:0] n;
        if (a == hlt_addr) return 16'hF000;
        n = {13'd0, a[3:1]} + 16'd1;
        return n * 16'h1111;
    endfunction

    always_comb imem_data = memf(imem_addr);
    assign imem_valid = hit & imem_req;

    fetch_pc_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .imem_valid     (imem_valid),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .pc_out         (pc_out),
        .halted         (halted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] a);
        exp_t e;
        e.pc   = a;
        e.inst = memf(a);
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake completes when if_valid is high and IF/ID is not stalled
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n === 1'b1 && if_valid === 1'b1 && stall === 1'b0) begin
            if (sb.size() == 0) begin
                nchk++;
                nerr++;
                $error("FAIL unexpected_delivery: got pc %0h inst %0h expected none", if_pc, if_inst);
            end else begin
                e = sb.pop_front();
                chk("deliver_pc", {16'h0, if_pc}, {16'h0, e.pc});
                chk("deliver_inst", {16'h0, if_inst}, {16'h0, e.inst});
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        stall = 1'b0; hit = 1'b1; hlt_addr = 16'h0010;
        #2 rst_n = 1'b0;
        #4;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc_out, 16'h0000);
        push(16'h0000); push(16'h0002);
        #6 rst_n = 1'b1;
        step();  // first RUN cycle
        chk("first_valid", if_valid, 1);
        chk("first_addr", imem_addr, 16'h0000);
        chk("first_req", imem_req, 1);
        step();
        chk("seq_addr", imem_addr, 16'h0002);
        step();  // miss at 0x0004
        hit = 1'b0; #1;
        chk("miss_addr0", imem_addr, 16'h0004);
        chk("miss_valid0", if_valid, 0);
        step();
        chk("miss_addr1", imem_addr, 16'h0004);
        chk("miss_req1", imem_req, 1);
        step();
        chk("miss_addr2", imem_addr, 16'h0004);
        chk("miss_valid2", if_valid, 0);
        step();
        push(16'h0004); hit = 1'b1; #1;
        chk("miss_ret_valid", if_valid, 1);
        chk("miss_ret_pc", if_pc, 16'h0004);
        step();  // miss at 0x0006, redirected mid-miss
        hit = 1'b0; #1;
        chk("miss2_addr", imem_addr, 16'h0006);
        step();
        redirect_valid = 1'b1; redirect_pc = 16'h0040;
        step();
        redirect_valid = 1'b0; #1;
        chk("drain_req", imem_req, 1);
        chk("drain_addr", imem_addr, 16'h0006);
        hit = 1'b1; #1;
        chk("drain_drop", if_valid, 0);
        step();
        chk("redir_addr", imem_addr, 16'h0040);
        push(16'h0040);
        step();  // redirect on a hit discards the returning data
        redirect_valid = 1'b1; redirect_pc = 16'h0008; #1;
        chk("redir_hit_squash", if_valid, 0);
        step();
        redirect_valid = 1'b0; stall = 1'b1; push(16'h0008); #1;
        chk("stall_valid", if_valid, 1);
        chk("stall_pc", if_pc, 16'h0008);
        step();
        chk("hold_req", imem_req, 0);
        chk("hold_valid", if_valid, 1);
        chk("hold_pc", if_pc, 16'h0008);
        chk("hold_inst", if_inst, 16'h5555);
        chk("hold_nextpc", pc_out, 16'h000A);
        step();
        chk("hold2_pc", if_pc, 16'h0008);
        stall = 1'b0;
        push(16'h000A); push(16'h000C); push(16'h000E); push(16'h0010);
        step();
        chk("resume_addr", imem_addr, 16'h000A);
        step(); step();
        step();
        chk("hlt_inst", if_inst, 16'hF000);
        step();
        chk("halted", halted, 1);
        chk("halted_req", imem_req, 0);
        chk("halted_valid", if_valid, 0);
        chk("halted_pc", pc_out, 16'h0012);
        step();
        chk("halted_stay", halted, 1);
        redirect_valid = 1'b1; redirect_pc = 16'h0020; push(16'h0020);
        step();
        redirect_valid = 1'b0; #1;
        chk("unhalt", halted, 0);
        chk("unhalt_addr", imem_addr, 16'h0020);
        step();
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        step();
        redirect_valid = 1'b0; push(16'hFFFE); #1;
        chk("wrap_start", imem_addr, 16'hFFFE);
        step();
        chk("wrap_addr", imem_addr, 16'h0000);
        stall = 1'b1;
        step();
        chk("hold_wrap_valid", if_valid, 1);
        chk("hold_wrap_pc", if_pc, 16'h0000);
        #2 rst_n = 1'b0; #1;
        chk("arst_valid", if_valid, 0);
        chk("arst_req", imem_req, 0);
        chk("arst_inst", if_inst, 16'h0000);
        chk("arst_ifpc", if_pc, 16'h0000);
        chk("arst_pc", pc_out, 16'h0000);
        #5;
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
